// File: rtl/dot_product_accumulator.sv
// Signed dot-product reduction: sums LEN 64-bit products into an ACC_W-bit result
// behind valid/ready handshakes. Define DOT_ACC_SATURATE_EN for saturating adds and s_ovf.
module dot_product_accumulator #(
  parameter int LEN   = 8,
  parameter int ACC_W = 72
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p_valid,
  input  logic signed [63:0]      p_data,
  output logic                    p_ready,
  input  logic                    clear,
  output logic                    s_valid,
  output logic signed [ACC_W-1:0] s_data,
  input  logic                    s_ready,
  output logic                    s_ovf,
  output logic [7:0]              count
);

  localparam logic [7:0] LAST = 8'(LEN - 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              count_q, count_d;
  logic                    s_valid_q, s_valid_d;
  logic signed [ACC_W-1:0] s_data_q, s_data_d;

  logic                    accept;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_raw;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;

`ifdef DOT_ACC_SATURATE_EN
  logic sticky_q, sticky_d;
  logic s_ovf_q, s_ovf_d;

  // Same-sign operands whose sum flips sign have overflowed.
  function automatic logic detect_ovf(input logic signed [ACC_W-1:0] a,
                                      input logic signed [ACC_W-1:0] b,
                                      input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W-1:0] s,
                                                      input logic ovf,
                                                      input logic neg);
    logic signed [ACC_W-1:0] max_v;
    max_v = {1'b0, {(ACC_W-1){1'b1}}};
    if (!ovf) return s;
    return neg ? ~max_v : max_v;
  endfunction
`endif

  assign p_ready  = !rst && !clear && (state_q != HOLD);
  assign accept   = p_valid && p_ready;
  // Size cast of a signed operand sign-extends the product.
  assign prod_ext = ACC_W'(p_data);
  assign sum_raw  = acc_q + prod_ext;

`ifdef DOT_ACC_SATURATE_EN
  assign add_ovf = detect_ovf(acc_q, prod_ext, sum_raw);
  assign sum     = saturate(sum_raw, add_ovf, acc_q[ACC_W-1]);
`else
  assign add_ovf = 1'b0;
  assign sum     = sum_raw;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
`ifdef DOT_ACC_SATURATE_EN
    sticky_d  = sticky_q;
    s_ovf_d   = s_ovf_q;
`endif
    if (clear) begin
      acc_d     = '0;
      count_d   = '0;
      s_valid_d = 1'b0;
      state_d   = IDLE;
`ifdef DOT_ACC_SATURATE_EN
      sticky_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            if (count_q == LAST) begin
              s_data_d  = sum;
              s_valid_d = 1'b1;
              acc_d     = '0;
              count_d   = '0;
              state_d   = HOLD;
`ifdef DOT_ACC_SATURATE_EN
              s_ovf_d   = sticky_q | add_ovf;
              sticky_d  = 1'b0;
`endif
            end else begin
              acc_d   = sum;
              count_d = count_q + 8'd1;
              state_d = ACC;
`ifdef DOT_ACC_SATURATE_EN
              sticky_d = sticky_q | add_ovf;
`endif
            end
          end
        end
        HOLD: begin
          if (s_ready) begin
            s_valid_d = 1'b0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
`ifdef DOT_ACC_SATURATE_EN
      sticky_q  <= 1'b0;
      s_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
`ifdef DOT_ACC_SATURATE_EN
      sticky_q  <= sticky_d;
      s_ovf_q   <= s_ovf_d;
`endif
    end
  end

  assign s_valid = s_valid_q;
  assign s_data  = s_data_q;
  assign count   = count_q;
`ifdef DOT_ACC_SATURATE_EN
  assign s_ovf   = s_ovf_q;
`else
  assign s_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator with a result scoreboard.
module tb_dot_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_valid, clear, s_ready;
  logic [63:0] p_data;
  logic        p_ready, s_valid, s_ovf;
  logic [71:0] s_data;
  logic [7:0]  count;

  logic        p2_valid, clear2, s2_ready;
  logic [63:0] p2_data;
  logic        p2_ready, s2_valid, s2_ovf;
  logic [63:0] s2_data;
  logic [7:0]  count2;

  typedef struct { logic [71:0] d; logic o; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dot_product_accumulator #(.LEN(4), .ACC_W(72)) dut (
    .clk(clk), .rst(rst), .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready),
    .clear(clear), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .s_ovf(s_ovf), .count(count)
  );

  dot_product_accumulator #(.LEN(2), .ACC_W(64)) dut2 (
    .clk(clk), .rst(rst), .p_valid(p2_valid), .p_data(p2_data), .p_ready(p2_ready),
    .clear(clear2), .s_valid(s2_valid), .s_data(s2_data), .s_ready(s2_ready),
    .s_ovf(s2_ovf), .count(count2)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [71:0] d, input logic o);
    exp_t e;
    e.d = d;
    e.o = o;
    sb.push_back(e);
  endtask

  // Offer one product and return just after the edge that accepted it.
  task automatic send(input logic [63:0] v);
    int n;
    n = 0;
    p_valid = 1'b1;
    p_data  = v;
    #1;
    while (!p_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("p_ready_timeout", 72'(p_ready), 72'd1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every consumed result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && s_valid && s_ready) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 72'(sb.size()), 72'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("s_data", s_data, e.d);
        chk("s_ovf", 72'(s_ovf), 72'(e.o));
      end
    end
  end

  initial begin
    logic signed [71:0] neg3;
    logic [63:0]        ovf_exp_d;
    logic               ovf_exp_o;
    neg3 = -72'sd3;
`ifdef DOT_ACC_SATURATE_EN
    ovf_exp_d = 64'h7FFF_FFFF_FFFF_FFFF;
    ovf_exp_o = 1'b1;
`else
    ovf_exp_d = 64'h8000_0000_0000_0000;
    ovf_exp_o = 1'b0;
`endif

    rst = 1'b1; p_valid = 1'b0; p_data = '0; clear = 1'b0; s_ready = 1'b1;
    p2_valid = 1'b0; p2_data = '0; clear2 = 1'b0; s2_ready = 1'b1;
    tick(); tick();
    chk("rst_p_ready", 72'(p_ready), 72'd0);
    chk("rst_s_valid", 72'(s_valid), 72'd0);
    chk("rst_s_data", s_data, 72'd0);
    chk("rst_s_ovf", 72'(s_ovf), 72'd0);
    chk("rst_count", 72'(count), 72'd0);
    chk("rst_p2_ready", 72'(p2_ready), 72'd0);
    rst = 1'b0;
    #1;
    chk("idle_p_ready", 72'(p_ready), 72'd1);

    // Basic sum 1+2+3+4
    push(72'd10, 1'b0);
    send(64'd1); send(64'd2);
    chk("basic_count2", 72'(count), 72'd2);
    send(64'd3); send(64'd4);
    p_valid = 1'b0;
    chk("basic_s_valid", 72'(s_valid), 72'd1);
    chk("basic_hold_p_ready", 72'(p_ready), 72'd0);
    chk("basic_count_clr", 72'(count), 72'd0);
    tick();
    chk("basic_s_valid_drop", 72'(s_valid), 72'd0);
    chk("basic_p_ready_back", 72'(p_ready), 72'd1);

    // Signed mix -5 + 3 + -2^63 + (2^63-1) = -3
    push(neg3, 1'b0);
    send(-64'sd5); send(64'd3);
    send(64'h8000_0000_0000_0000); send(64'h7FFF_FFFF_FFFF_FFFF);
    p_valid = 1'b0;
    tick(); tick();

    // Backpressure with a stalled consumer and a waiting product
    s_ready = 1'b0;
    push(72'd4, 1'b0);
    send(64'd1); send(64'd1); send(64'd1); send(64'd1);
    p_valid = 1'b1;
    p_data  = 64'd7;
    for (int i = 0; i < 5; i++) begin
      chk("bp_p_ready", 72'(p_ready), 72'd0);
      chk("bp_s_valid", 72'(s_valid), 72'd1);
      chk("bp_s_data", s_data, 72'd4);
      tick();
    end
    push(72'd28, 1'b0);
    s_ready = 1'b1;
    send(64'd7); send(64'd7); send(64'd7); send(64'd7);
    p_valid = 1'b0;
    tick(); tick();
    chk("bp_after_s_valid", 72'(s_valid), 72'd0);
    chk("bp_after_count", 72'(count), 72'd0);

    // Clear mid-accumulation
    send(64'd5); send(64'd5);
    chk("clr_count2", 72'(count), 72'd2);
    clear = 1'b1; p_valid = 1'b1; p_data = 64'd9;
    #1;
    chk("clr_p_ready", 72'(p_ready), 72'd0);
    tick();
    clear = 1'b0; p_valid = 1'b0;
    chk("clr_count0", 72'(count), 72'd0);
    chk("clr_s_valid", 72'(s_valid), 72'd0);
    push(72'd4, 1'b0);
    send(64'd1); send(64'd1); send(64'd1); send(64'd1);
    p_valid = 1'b0;
    tick(); tick();

    // Clear while a result is held: that result is discarded
    s_ready = 1'b0;
    send(64'd2); send(64'd2); send(64'd2); send(64'd2);
    p_valid = 1'b0;
    chk("clrh_s_valid", 72'(s_valid), 72'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("clrh_s_valid_drop", 72'(s_valid), 72'd0);
    chk("clrh_p_ready", 72'(p_ready), 72'd1);
    chk("clrh_count", 72'(count), 72'd0);
    s_ready = 1'b1;
    tick();

    // Reset after 3 of 4 products
    send(64'd3); send(64'd3); send(64'd3);
    p_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rmid_s_valid", 72'(s_valid), 72'd0);
    chk("rmid_s_data", s_data, 72'd0);
    chk("rmid_s_ovf", 72'(s_ovf), 72'd0);
    chk("rmid_count", 72'(count), 72'd0);
    chk("rmid_p_ready", 72'(p_ready), 72'd0);
    rst = 1'b0;
    push(72'd8, 1'b0);
    send(64'd2); send(64'd2); send(64'd2); send(64'd2);
    p_valid = 1'b0;
    tick(); tick();

    // Overflow on the 64-bit, LEN=2 instance: 2^62 + 2^62
    chk("ovf_p2_ready", 72'(p2_ready), 72'd1);
    p2_valid = 1'b1;
    p2_data  = 64'h4000_0000_0000_0000;
    tick();
    chk("ovf_count1", 72'(count2), 72'd1);
    tick();
    p2_valid = 1'b0;
    chk("ovf_s_valid", 72'(s2_valid), 72'd1);
    chk("ovf_s_data", 72'(s2_data), 72'(ovf_exp_d));
    chk("ovf_s_ovf", 72'(s2_ovf), 72'(ovf_exp_o));
    tick();
    chk("ovf_s_valid_drop", 72'(s2_valid), 72'd0);

    repeat (3) tick();
    chk("sb_drained", 72'(sb.size()), 72'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Downstream consumer of the 32x32 sequential multiplier's signed 64-bit products. It accumulates a fixed-length run of LEN products into a wide signed sum and presents each finished sum on a valid/ready output port. Backpressure is fed upstream through `p_ready` so that no product is ever dropped. It is the reduction stage of the dot-product datapath, sitting between the multiplier and the result writeback.

## Interface
- `LEN`, 8: products summed per result; legal range 1..255.
- `ACC_W`, 72: accumulator and result width in bits; must be at least 64.
- `clk`  in  1  the single clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p_valid`  in  1  a product is offered on `p_data`.
- `p_data`  in  64  signed two's-complement product from the multiplier.
- `p_ready`  out  1  the block accepts a product this cycle.
- `clear`  in  1  synchronous abort; discards the partial sum and any held result.
- `s_valid`  out  1  a finished sum is on `s_data`.
- `s_data`  out  ACC_W  signed sum of LEN products.
- `s_ready`  in  1  the consumer takes the sum.
- `s_ovf`  out  1  signed overflow occurred while forming this sum.
- `count`  out  8  number of products accepted into the current sum.

## Operation
- States:
  - IDLE: `count`=0, accumulator=0.
  - ACC: one or more products accepted.
  - HOLD: a result is held, waiting for `s_ready`.
- `p_ready` = !rst && !clear && state != HOLD. This signal is combinational.
- Accept condition: `p_valid` && `p_ready`.
- Each accepted product is sign-extended to ACC_W and added to the accumulator. Overflow is detected as: both operands have the same sign and the sum's sign differs from theirs.
- Accepted product with `count` < LEN-1: the accumulator takes the sum, `count` increments, and the state becomes ACC.
- Accepted product with `count` == LEN-1:
  - `s_data` takes accumulator + product.
  - `s_ovf` takes the sticky overflow flag OR this addition's overflow.
  - `s_valid` goes to 1.
  - The accumulator, `count` and the sticky flag clear.
  - The state becomes HOLD.
  - When LEN=1, every accepted product takes this path directly from IDLE.
- In HOLD: when `s_valid` && `s_ready`, `s_valid` drops on the next edge and the state returns to IDLE. `s_data` and `s_ovf` keep their values until they are overwritten.
- `clear` has priority over everything except `rst`. On the next edge: the accumulator, `count` and the sticky flag clear, `s_valid` goes to 0, and the state becomes IDLE. A product offered in that cycle is not accepted, because `p_ready` is 0.
- `rst` return values: state IDLE, `s_valid` 0, `s_data` 0, `s_ovf` 0, `count` 0, accumulator 0. `p_ready` is 0 while `rst` is high.
- Reset asserted mid-accumulation or during HOLD discards all partial and held data.

## Timing
- An accepted product is reflected in the accumulator and `count` at the next edge.
- `s_valid` rises at the same edge that accepts the LEN-th product.
- Fastest throughput is LEN+1 cycles per result, with one bubble cycle in HOLD. A result is consumed in its first HOLD cycle when `s_ready` is already high.
- `s_valid`, `s_data` and `s_ovf` stay stable while `s_valid`=1 and `s_ready`=0.
- `p_ready` stays 0 for the entire HOLD period.
- The upstream multiplier must hold `p_data` and keep `p_valid` high until a cycle where `p_ready`=1.

## Configuration
- `DOT_ACC_SATURATE_EN` defined:
  - Every addition that overflows clamps to 2^(ACC_W-1)-1 on positive overflow, or -2^(ACC_W-1) on negative overflow.
  - Overflow sets the sticky flag, which is reported through `s_ovf`.
- `DOT_ACC_SATURATE_EN` undefined:
  - Additions wrap modulo 2^ACC_W.
  - No overflow detection logic is built.
  - `s_ovf` is constant 0.

## Test plan
- Basic sum: LEN=4, products 1, 2, 3, 4 on consecutive cycles with `s_ready`=1 → `s_valid` is high for 1 cycle with `s_data`=10 and `s_ovf`=0, and `p_ready` is low for exactly that cycle.
- Signed mix: LEN=4, products -5, 3, -2^63, 2^63-1 → `s_data`=-3 (sign-extended to 72 bits).
- Backpressure: hold `s_ready`=0 for 5 cycles after a result, with `p_valid` held high and `p_data`=7 → `p_ready` stays 0 and `s_data` stays stable. After `s_ready` rises, the next sum counts 7 exactly LEN times, with no loss or duplication.
- Clear: LEN=4, assert `clear` after 2 products → `count`=0 at the next edge. The following products 1, 1, 1, 1 yield `s_data`=4. A second case asserts `clear` during HOLD → `s_valid` drops at the next edge.
- Overflow: ACC_W=64, LEN=2, products 2^62, 2^62. With `DOT_ACC_SATURATE_EN` → `s_data`=2^63-1 and `s_ovf`=1. Without it → `s_data`=-2^63 and `s_ovf`=0.
- Reset mid-run: assert `rst` after 3 of 4 products → all outputs are 0 and `count`=0. The next 4 products of value 2 give `s_data`=8.
